alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 158 +++++++++++++++
 tb/tb_alu_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops, iterative shift-add multiply over WIDTH cycles.
// Define ALU_SEQ_MULHI_EN to expose the high half of the product on ResHi.
module alu_seq #(
    parameter  int WIDTH = 32,
    localparam int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Res,
`ifdef ALU_SEQ_MULHI_EN
    output logic [WIDTH-1:0] ResHi,
`endif
    output logic             Zflag,
    output logic             Cflag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:0]       dbg_state
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_ABSD = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_SLTU = 3'b111;

    logic [0:0]         state;
    logic [CNTW-1:0]    cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;

    logic               accept;
    logic               mul_done;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic               lt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_next;
    logic               load_en;
    logic [WIDTH-1:0]   ld_res;
    logic [WIDTH-1:0]   ld_hi;
    logic               ld_c;

    // Handshake: a transfer happens on an edge where valid && ready; the
    // producer holds data until then, the consumer may raise ready at will.
    assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_done  = (state == S_MUL) && (cnt == CNTW'(WIDTH - 1));
    assign dbg_state = state;

    assign add_full = {1'b0, A} + {1'b0, B};
    assign sub_full = {1'b0, A} - {1'b0, B};
    assign lt       = sub_full[WIDTH];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op)
            OP_ADD:  begin alu_res = add_full[WIDTH-1:0]; alu_c = add_full[WIDTH]; end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_SUB:  begin alu_res = sub_full[WIDTH-1:0]; alu_c = lt; end
            OP_ABSD: begin alu_res = lt ? (B - A) : (A - B); alu_c = lt; end
            OP_SHL:  alu_res = A << B[CNTW-2:0];
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, lt};
            default: alu_res = '0;
        endcase
    end

    // The multiplier sits in the low half of acc and is consumed from bit 0
    // as partial sums shift in from the top.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    assign acc_next = {mul_sum, acc[WIDTH-1:1]};

    always_comb begin
        load_en = 1'b0;
        ld_res  = alu_res;
        ld_hi   = '0;
        ld_c    = alu_c;
        if (mul_done) begin
            load_en = 1'b1;
            ld_res  = acc_next[WIDTH-1:0];
            ld_hi   = acc_next[2*WIDTH-1:WIDTH];
            ld_c    = |acc_next[2*WIDTH-1:WIDTH];
        end else if (accept && (op != OP_MUL)) begin
            load_en = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            cnt   <= '0;
            mcand <= '0;
            acc   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && (op == OP_MUL)) begin
                        state <= S_MUL;
                        cnt   <= '0;
                        mcand <= A;
                        acc   <= {{WIDTH{1'b0}}, B};
                    end
                end
                S_MUL: begin
                    acc <= acc_next;
                    if (mul_done) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Res       <= '0;
            Zflag     <= 1'b0;
            Cflag     <= 1'b0;
            out_valid <= 1'b0;
        end else if (load_en) begin
            Res       <= ld_res;
            Zflag     <= (ld_res == '0);
            Cflag     <= ld_c;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ALU_SEQ_MULHI_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ResHi <= '0;
        end else if (load_en) begin
            ResHi <= ld_hi;
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32): single-cycle ops, back-to-back issue,
// iterative multiply timing, backpressure hold and asynchronous reset mid-multiply.
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] res;
`ifdef ALU_SEQ_MULHI_EN
    logic [31:0] res_hi;
`endif
    logic        zflag;
    logic        cflag;
    logic        out_valid;
    logic        out_ready;
    logic [0:0]  dbg_state;

    int tests_run = 0;
    int fails = 0;

    alu_seq #(.WIDTH(32)) dut (
        .CLK(clk),
        .RST(rst),
        .A(a),
        .B(b),
        .op(op),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .Res(res),
`ifdef ALU_SEQ_MULHI_EN
        .ResHi(res_hi),
`endif
        .Zflag(zflag),
        .Cflag(cflag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %0b expected 0", out_valid); end
        tests_run++; if (res !== 32'd0) begin fails++; $display("FAIL rst_res: got %0h expected 0", res); end
        tests_run++; if ({zflag, cflag} !== 2'b00) begin fails++; $display("FAIL rst_flags: got %b expected 00", {zflag, cflag}); end
        tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %0b expected 1", in_ready); end
        tests_run++; if (dbg_state !== 1'b0) begin fails++; $display("FAIL rst_state: got %0b expected 0", dbg_state); end
    endtask

    task automatic test_add();
        a = 32'd300; b = 32'd100; op = 3'b000; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_valid: got %0b expected 1", out_valid); end
        tests_run++; if (res !== 32'd400) begin fails++; $display("FAIL add_res: got %0d expected 400", res); end
        tests_run++; if ({zflag, cflag} !== 2'b00) begin fails++; $display("FAIL add_flags: got %b expected 00", {zflag, cflag}); end
`ifdef ALU_SEQ_MULHI_EN
        tests_run++; if (res_hi !== 32'd0) begin fails++; $display("FAIL add_reshi: got %0h expected 0", res_hi); end
`endif
        step();
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add_consumed: got %0b expected 0", out_valid); end
        // Carry out wraps to zero
        a = 32'hFFFF_FFFF; b = 32'd1; op = 3'b000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        tests_run++; if ({res, zflag, cflag} !== {32'd0, 2'b11}) begin fails++; $display("FAIL add_carry: got %0h z%0b c%0b expected 0 z1 c1", res, zflag, cflag); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [4];
        logic [31:0] exp [4];
        ops = '{3'b001, 3'b010, 3'b011, 3'b101};
        exp = '{32'd36, 32'd364, 32'd200, 32'd200};
        a = 32'd300; b = 32'd100; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op = ops[i]; in_valid = 1'b1;
            tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d]: got %0b expected 1", i, in_ready); end
            step();
            tests_run++; if (out_valid !== 1'b1 || res !== exp[i] || cflag !== 1'b0) begin fails++; $display("FAIL b2b_res[%0d]: got v%0b %0d c%0b expected v1 %0d c0", i, out_valid, res, cflag, exp[i]); end
        end
        // Reverse-ordered operands: absdiff, sltu, and a shift using only B[4:0]
        a = 32'd100; b = 32'd300; op = 3'b101;
        step();
        tests_run++; if ({res, cflag} !== {32'd200, 1'b1}) begin fails++; $display("FAIL absd_lt: got %0d c%0b expected 200 c1", res, cflag); end
        op = 3'b111;
        step();
        tests_run++; if ({res, cflag} !== {32'd1, 1'b0}) begin fails++; $display("FAIL sltu: got %0d c%0b expected 1 c0", res, cflag); end
        a = 32'd3; b = 32'h0000_0024; op = 3'b110;
        step();
        in_valid = 1'b0;
        tests_run++; if ({res, zflag, cflag} !== {32'd48, 2'b00}) begin fails++; $display("FAIL shl: got %0d z%0b c%0b expected 48 z0 c0", res, zflag, cflag); end
        step();
    endtask

    task automatic run_mul(input logic [31:0] ma, input logic [31:0] mb, output int lat, output bit busy_err);
        a = ma; b = mb; op = 3'b100; in_valid = 1'b1; out_ready = 1'b1;
        step();
        // Keep offering an ADD to confirm it is ignored while multiplying
        a = 32'd7; b = 32'd8; op = 3'b000;
        lat = 0; busy_err = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready !== 1'b0) busy_err = 1'b1;
            step();
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mul();
        int lat;
        bit busy_err;
        run_mul(32'd300, 32'd100, lat, busy_err);
        tests_run++; if (lat !== 32) begin fails++; $display("FAIL mul_latency: got %0d expected 32", lat); end
        tests_run++; if (busy_err) begin fails++; $display("FAIL mul_busy: got in_ready=1 during multiply expected 0"); end
        tests_run++; if ({res, zflag, cflag} !== {32'd30000, 2'b00}) begin fails++; $display("FAIL mul_small: got %0d z%0b c%0b expected 30000 z0 c0", res, zflag, cflag); end
        step();
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mul_ignored_add: got out_valid %0b expected 0", out_valid); end
        run_mul(32'h0001_0000, 32'h0001_0000, lat, busy_err);
        tests_run++; if ({res, zflag, cflag} !== {32'd0, 2'b11}) begin fails++; $display("FAIL mul_2p32: got %0h z%0b c%0b expected 0 z1 c1", res, zflag, cflag); end
`ifdef ALU_SEQ_MULHI_EN
        tests_run++; if (res_hi !== 32'd1) begin fails++; $display("FAIL mul_2p32_hi: got %0h expected 1", res_hi); end
`endif
        step();
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busy_err);
        tests_run++; if ({res, zflag, cflag} !== {32'd1, 2'b01}) begin fails++; $display("FAIL mul_max: got %0h z%0b c%0b expected 1 z0 c1", res, zflag, cflag); end
`ifdef ALU_SEQ_MULHI_EN
        tests_run++; if (res_hi !== 32'hFFFF_FFFE) begin fails++; $display("FAIL mul_max_hi: got %0h expected fffffffe", res_hi); end
`endif
        step();
    endtask

    task automatic test_sub();
        a = 32'd100; b = 32'd100; op = 3'b011; in_valid = 1'b1; out_ready = 1'b1;
        step();
        tests_run++; if ({res, zflag, cflag} !== {32'd0, 2'b10}) begin fails++; $display("FAIL sub_eq: got %0h z%0b c%0b expected 0 z1 c0", res, zflag, cflag); end
        b = 32'd300;
        step();
        in_valid = 1'b0;
        tests_run++; if ({res, zflag, cflag} !== {32'hFFFF_FF38, 2'b01}) begin fails++; $display("FAIL sub_borrow: got %0h z%0b c%0b expected ffffff38 z0 c1", res, zflag, cflag); end
        step();
    endtask

    task automatic test_backpressure();
        a = 32'd5; b = 32'd7; op = 3'b000; in_valid = 1'b1; out_ready = 1'b0;
        step();
        a = 32'd10; b = 32'd20;
        for (int i = 0; i < 5; i++) begin
            tests_run++; if (out_valid !== 1'b1 || res !== 32'd12 || in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold[%0d]: got v%0b res %0d rdy %0b expected v1 12 rdy0", i, out_valid, res, in_ready); end
            step();
        end
        out_ready = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %0b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b1 || res !== 32'd30) begin fails++; $display("FAIL bp_next: got v%0b %0d expected v1 30", out_valid, res); end
        step();
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %0b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid_mul();
        a = 32'd300; b = 32'd100; op = 3'b100; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        tests_run++; if (in_ready !== 1'b0 || dbg_state !== 1'b1) begin fails++; $display("FAIL midmul_busy: got rdy %0b st %0b expected rdy0 st1", in_ready, dbg_state); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (out_valid !== 1'b0 || res !== 32'd0 || cflag !== 1'b0 || zflag !== 1'b0) begin fails++; $display("FAIL async_rst_out: got v%0b %0h z%0b c%0b expected all 0", out_valid, res, zflag, cflag); end
        tests_run++; if (in_ready !== 1'b1 || dbg_state !== 1'b0) begin fails++; $display("FAIL async_rst_state: got rdy %0b st %0b expected rdy1 st0", in_ready, dbg_state); end
        step();
        rst = 1'b0;
        step();
        a = 32'd1; b = 32'd2; op = 3'b000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b1 || res !== 32'd3) begin fails++; $display("FAIL post_rst_add: got v%0b %0d expected v1 3", out_valid, res); end
        step();
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; op = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) step();
        test_reset();
        rst = 1'b0;
        step();
        test_add();
        test_back_to_back();
        test_mul();
        test_sub();
        test_backpressure();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
